// File: rtl/sysmem_block_mover_pkg.sv
// Shared definitions for system-memory initiators.
// Holds the word width, memory depth, logic constants and the 2-bit FSM
// state encoding so sibling initiators can reuse the same values.
package sysmem_block_mover_pkg;

    localparam int WordSize = 32;
    localparam int MemWords = 128;

    localparam logic LogicOne  = 1'b1;
    localparam logic LogicZero = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/sysmem_xfer_buf.sv
// Local transfer buffer: DEPTH x N register file.
// Ports:
//   clk_i      - clock, write on rising edge
//   wr_en_i    - write enable
//   wr_idx_i   - write index
//   wr_data_i  - write data
//   rd_idx_i   - read index (combinational read)
//   rd_data_o  - read data
// Contents are not reset; every word is written before it is read.
module sysmem_xfer_buf #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic [N-1:0]  wr_data_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [N-1:0]  rd_data_o
);

    logic [N-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/sysmem_block_mover.sv
// Block copy engine on one external port of the shared system memory.
// A Start in IDLE latches a command; Len words are read from SrcAddr into a
// local buffer, then written to DstAddr. Stall freezes the current access.
// Ports:
//   Clk, Rst_n        - clock, asynchronous active-low reset
//   Start             - command strobe (IDLE only)
//   SrcAddr, DstAddr  - first source / destination word address
//   Len               - word count, 0..DEPTH
//   Stall             - higher-priority port owns memory this cycle
//   Busy, Done, Err   - status; Done/Err are one-cycle pulses
//   DAddrE, DOutE     - memory address and write data
//   DReadE, DWriteE   - memory strobes
//   DInE              - memory read data, combinational
//   DbgState          - current FSM state, for observation only
module sysmem_block_mover
    import sysmem_block_mover_pkg::*;
#(
    parameter int N     = WordSize,
    parameter int WORDS = MemWords,
    parameter int DEPTH = 8
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Start,
    input  logic [N-1:0]           SrcAddr,
    input  logic [N-1:0]           DstAddr,
    input  logic [$clog2(DEPTH):0] Len,
    input  logic                   Stall,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Err,
    output logic [N-1:0]           DAddrE,
    output logic [N-1:0]           DOutE,
    output logic                   DReadE,
    output logic                   DWriteE,
    input  logic [N-1:0]           DInE,
    output xfer_state_e            DbgState
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    xfer_state_e   state_q, state_d;
    logic [N-1:0]  src_q, src_d;
    logic [N-1:0]  dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic          err_q, err_d;

    logic          buf_we;
    logic [N-1:0]  buf_rd;
    logic          last_idx;
    logic          reject;
    logic [N:0]    src_end;
    logic [N:0]    dst_end;

    // End addresses are formed one bit wider so a wrap past 2^N cannot
    // slip under the WORDS limit.
    assign src_end = {1'b0, SrcAddr} + (N+1)'(Len);
    assign dst_end = {1'b0, DstAddr} + (N+1)'(Len);
    assign reject  = (Len > LW'(DEPTH))
                   || (src_end > (N+1)'(WORDS))
                   || (dst_end > (N+1)'(WORDS));

    assign last_idx = (idx_q == (len_q - LW'(1)));

    sysmem_xfer_buf #(
        .N     (N),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_buf (
        .clk_i     (Clk),
        .wr_en_i   (buf_we),
        .wr_idx_i  (idx_q[IW-1:0]),
        .wr_data_i (DInE),
        .rd_idx_i  (idx_q[IW-1:0]),
        .rd_data_o (buf_rd)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            err_q   <= LogicZero;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        err_d   = err_q;
        buf_we  = LogicZero;
        Busy    = LogicZero;
        Done    = LogicZero;
        Err     = LogicZero;
        DAddrE  = '0;
        DOutE   = '0;
        DReadE  = LogicZero;
        DWriteE = LogicZero;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    src_d = SrcAddr;
                    dst_d = DstAddr;
                    len_d = Len;
                    idx_d = '0;
                    // A zero-length command completes cleanly even if its
                    // addresses would be out of range.
                    err_d = reject && (Len != '0);
                    if ((Len == '0) || reject) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                Busy   = LogicOne;
                DReadE = LogicOne;
                DAddrE = src_q + N'(idx_q);
                if (!Stall) begin
                    buf_we = LogicOne;
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            ST_WRITE: begin
                Busy    = LogicOne;
                DWriteE = LogicOne;
                DAddrE  = dst_q + N'(idx_q);
                DOutE   = buf_rd;
                if (!Stall) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = ST_FIN;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
            end
            ST_FIN: begin
                Busy    = LogicOne;
                Done    = LogicOne;
                Err     = err_q;
                err_d   = LogicZero;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign DbgState = state_q;

endmodule

// File: tb/tb_sysmem_block_mover.sv
module tb_sysmem_block_mover;
    import sysmem_block_mover_pkg::*;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [31:0] SrcAddr;
    logic [31:0] DstAddr;
    logic [3:0]  Len;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [31:0] DAddrE;
    logic [31:0] DOutE;
    logic        DReadE;
    logic        DWriteE;
    logic [31:0] DInE;
    xfer_state_e DbgState;

    int total;
    int bad;

    // System memory model with a backdoor write port for test setup.
    logic [31:0] mem [128];
    logic        bd_we;
    logic [6:0]  bd_addr;
    logic [31:0] bd_data;

    assign DInE = (DAddrE < 32'd128) ? mem[DAddrE[6:0]] : 32'd0;

    always @(posedge Clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (DWriteE && !Stall && (DAddrE < 32'd128)) begin
            mem[DAddrE[6:0]] <= DOutE;
        end
    end

    sysmem_block_mover #(
        .N     (32),
        .WORDS (128),
        .DEPTH (8)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .SrcAddr  (SrcAddr),
        .DstAddr  (DstAddr),
        .Len      (Len),
        .Stall    (Stall),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err),
        .DAddrE   (DAddrE),
        .DOutE    (DOutE),
        .DReadE   (DReadE),
        .DWriteE  (DWriteE),
        .DInE     (DInE),
        .DbgState (DbgState)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge Clk);
        bd_we   = 1'b1;
        bd_addr = 7'(a);
        bd_data = d;
        @(negedge Clk);
        bd_we   = 1'b0;
    endtask

    // Runs one command and checks every cycle against a word-count model:
    // reads are pending until Len unstalled read cycles have passed, then
    // writes likewise, then one Done cycle. Memory is compared at the end.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int stall_pct,
                            input logic [63:0] stall_mask, input int restart_c,
                            input int exp_done, input string name);
        logic [31:0] img [128];
        logic [31:0] exp_q [$];
        bit          rej, finished, st, e_rd, e_wr, e_done;
        int          rl, r, w, stalls, done_c, nbad;
        logic [4:0]  e_flags, o_flags;
        logic [31:0] e_addr, e_data;

        rej = (len != 0) && ((len > 8) || (({32'd0, src} + 64'(len)) > 64'd128)
                             || (({32'd0, dst} + 64'(len)) > 64'd128));
        rl = rej ? 0 : len;
        for (int i = 0; i < 128; i++) img[i] = mem[i];
        for (int i = 0; i < rl; i++) exp_q.push_back(mem[src + 32'(i)]);
        for (int i = 0; i < rl; i++) img[dst + 32'(i)] = exp_q[i];

        @(negedge Clk);
        Start   = 1'b1;
        SrcAddr = src;
        DstAddr = dst;
        Len     = 4'(len);
        Stall   = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        r = 0; w = 0; stalls = 0; done_c = 0; finished = 1'b0;
        for (int c = 1; c <= 60 && !finished; c++) begin
            if (c > 1) @(negedge Clk);
            Start = (c == restart_c);
            if (Start) begin
                SrcAddr = 32'd0;
                DstAddr = 32'd100;
                Len     = 4'd3;
            end
            e_rd   = (r < rl);
            e_wr   = !e_rd && (w < rl);
            e_done = !e_rd && !e_wr;
            e_addr = e_rd ? src + 32'(r) : (e_wr ? dst + 32'(w) : 32'd0);
            e_data = (e_wr && exp_q.size() > 0) ? exp_q[0] : 32'd0;
            e_flags = {1'b1, e_done, e_done && rej, e_rd, e_wr};
            o_flags = {Busy, Done, Err, DReadE, DWriteE};
            total++;
            if (o_flags !== e_flags) begin
                bad++;
                $display("FAIL %s flags c=%0d {busy,done,err,rd,wr} got=%b exp=%b", name, c, o_flags, e_flags);
            end
            total++;
            if (DAddrE !== e_addr) begin
                bad++;
                $display("FAIL %s addr c=%0d got=%h exp=%h", name, c, DAddrE, e_addr);
            end
            total++;
            if (DOutE !== e_data) begin
                bad++;
                $display("FAIL %s wdata c=%0d got=%h exp=%h", name, c, DOutE, e_data);
            end
            st = stall_mask[c] || ($urandom_range(0, 99) < stall_pct);
            Stall = st;
            if (st && (e_rd || e_wr)) stalls++;
            if (e_rd && !st) r++;
            else if (e_wr && !st) begin
                w++;
                void'(exp_q.pop_front());
            end
            if (e_done) begin
                finished = 1'b1;
                done_c   = c;
            end
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL %s timeout waiting for done got=none exp=done", name);
        end
        total++;
        if (done_c != 2 * rl + 1 + stalls) begin
            bad++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_c, 2 * rl + 1 + stalls);
        end
        if (exp_done >= 0) begin
            total++;
            if (done_c != exp_done) begin
                bad++;
                $display("FAIL %s done_at got=k+%0d exp=k+%0d", name, done_c, exp_done);
            end
        end
        @(negedge Clk);
        Stall = 1'b0;
        Start = 1'b0;
        total++;
        if ({Busy, Done, DReadE, DWriteE} !== 4'b0000) begin
            bad++;
            $display("FAIL %s idle_after got=%b exp=0000", name, {Busy, Done, DReadE, DWriteE});
        end
        nbad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== img[i]) nbad++;
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s memory wrong_words got=%0d exp=0", name, nbad);
        end
    endtask

    task automatic test_reset();
        Rst_n   = 1'b0;
        Start   = 1'b0;
        SrcAddr = '0;
        DstAddr = '0;
        Len     = '0;
        Stall   = 1'b0;
        bd_we   = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        #2;
        total++;
        if ({Busy, Done, Err, DReadE, DWriteE} !== 5'b0 || DAddrE !== 32'd0 || DOutE !== 32'd0) begin
            bad++;
            $display("FAIL reset outputs got=%b/%h/%h exp=0/0/0",
                     {Busy, Done, Err, DReadE, DWriteE}, DAddrE, DOutE);
        end
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        for (int i = 0; i < 128; i++) poke(i, $urandom);
    endtask

    task automatic test_copy();
        for (int i = 0; i < 4; i++) poke(10 + i, 32'hA0 + 32'(i));
        run_xfer(32'd10, 32'd40, 4, 0, 64'd0, 0, 9, "copy");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) poke(40 + i, 32'h0);
        run_xfer(32'd10, 32'd40, 4, 0, (64'd1 << 2) | (64'd1 << 6), 0, 11, "stall");
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 8; i++) poke(20 + i, 32'(i));
        run_xfer(32'd20, 32'd22, 8, 0, 64'd0, 0, 17, "overlap");
    endtask

    task automatic test_reject();
        run_xfer(32'd0, 32'd50, 9, 0, 64'd0, 0, 1, "rej_len9");
        run_xfer(32'd125, 32'd50, 4, 0, 64'd0, 0, 1, "rej_src");
        run_xfer(32'd5, 32'd126, 3, 0, 64'd0, 0, 1, "rej_dst");
        run_xfer(32'hFFFF_FFFE, 32'd5, 4, 0, 64'd0, 0, 1, "rej_wrap");
        run_xfer(32'd124, 32'd0, 4, 0, 64'd0, 0, 9, "edge_ok");
    endtask

    task automatic test_len0_and_busy_start();
        run_xfer(32'd3, 32'd70, 0, 0, 64'd0, 0, 1, "len0");
        run_xfer(32'd30, 32'd60, 5, 0, 64'd0, 2, 11, "start_busy");
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] s [4];
        logic [31:0] d [4];
        for (int i = 0; i < 4; i++) begin
            s[i] = mem[60 + i];
            d[i] = mem[90 + i];
        end
        @(negedge Clk);
        Start = 1'b1; SrcAddr = 32'd60; DstAddr = 32'd90; Len = 4'd4; Stall = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        repeat (6) @(negedge Clk);
        total++;
        if (DWriteE !== 1'b1 || DAddrE !== 32'd92) begin
            bad++;
            $display("FAIL rst_mid pre got=%b/%h exp=1/%h", DWriteE, DAddrE, 32'd92);
        end
        Rst_n = 1'b0;
        #1;
        total++;
        if ({Busy, Done, Err, DReadE, DWriteE} !== 5'b0 || DAddrE !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid strobes got=%b/%h exp=0/0", {Busy, Done, Err, DReadE, DWriteE}, DAddrE);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        total++;
        if (mem[90] !== s[0] || mem[91] !== s[1] || mem[92] !== d[2] || mem[93] !== d[3]) begin
            bad++;
            $display("FAIL rst_mid memory got=%h %h %h %h exp=%h %h %h %h",
                     mem[90], mem[91], mem[92], mem[93], s[0], s[1], d[2], d[3]);
        end
        run_xfer(32'd60, 32'd90, 4, 0, 64'd0, 0, 9, "after_rst");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_xfer(32'($urandom_range(0, 127)), 32'($urandom_range(0, 127)),
                     int'($urandom_range(0, 9)), 30, 64'd0, 0, -1, "random");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_copy();
        test_stall();
        test_overlap();
        test_reject();
        test_len0_and_busy_start();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
